// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding block: operand-mux selects and mult/div timer states.
package hazard_pkg;

   localparam logic [1:0] FWD_NONE   = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: busy for MD_LAT cycles after an accepted start, then a one-cycle done pulse.
// Start is ignored while busy; reset aborts an operation without producing done.
module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start,
   output logic MD_BUSY,
   output logic MD_DONE
);

   localparam int CW = $clog2(MD_LAT);

   md_state_t       state_q;
   logic [CW-1:0]   cnt_q;
   logic            done_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= hazard_pkg::MD_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            hazard_pkg::MD_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= hazard_pkg::MD_BUSY;
                  cnt_q   <= CW'(MD_LAT - 1);
               end
            end
            hazard_pkg::MD_BUSY: begin
               // cnt==0 is still a busy cycle; done lands on the first idle cycle
               if (cnt_q == '0) begin
                  state_q <= hazard_pkg::MD_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q  <= cnt_q - 1'b1;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state_q <= hazard_pkg::MD_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign MD_BUSY = (state_q == hazard_pkg::MD_BUSY);
   assign MD_DONE = done_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding, load-use and mult/div HI/LO stall detection for the 5-stage pipeline.
// Optional saturating stall-cycle counter enabled by HAZ_STALL_CNT_EN.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [REG_AW-1:0] ID_RS,
   input  logic [REG_AW-1:0] ID_RT,
   input  logic              ID_USES_RS,
   input  logic              ID_USES_RT,
   input  logic              ID_MD_START,
   input  logic              ID_MD_READ,
   input  logic              FLUSH,
   input  logic [REG_AW-1:0] ID_EX_RS,
   input  logic [REG_AW-1:0] ID_EX_RT,
   input  logic [REG_AW-1:0] ID_EX_RD,
   input  logic              ID_EX_REGWRITE,
   input  logic              ID_EX_MEMREAD,
   input  logic [REG_AW-1:0] EX_MEM_RD,
   input  logic [REG_AW-1:0] MEM_WB_RD,
   input  logic              EX_MEM_REGWRITE,
   input  logic              MEM_WB_REGWRITE,
   output logic [1:0]        ALU_A,
   output logic [1:0]        ALU_B,
   output logic              STALL,
   output logic              BUBBLE,
   output logic              MD_BUSY,
   output logic              MD_DONE,
   output logic [CNT_W-1:0]  STALL_CNT
);

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (EX_MEM_REGWRITE && (src != '0) && (src == EX_MEM_RD))
         return FWD_EX_MEM;
      else if (MEM_WB_REGWRITE && (src != '0) && (src == MEM_WB_RD))
         return FWD_MEM_WB;
      else
         return FWD_NONE;
   endfunction

   logic lu_haz;
   logic md_haz;
   logic hazard;
   logic md_start;

   assign ALU_A = RESET ? FWD_NONE : fwd_sel(ID_EX_RS);
   assign ALU_B = RESET ? FWD_NONE : fwd_sel(ID_EX_RT);

   assign lu_haz = ID_EX_MEMREAD && ID_EX_REGWRITE && (ID_EX_RD != '0) &&
                   ((ID_USES_RS && (ID_RS == ID_EX_RD)) ||
                    (ID_USES_RT && (ID_RT == ID_EX_RD)));

   assign md_haz = MD_BUSY && (ID_MD_READ || ID_MD_START);

   // A flushed ID instruction is cancelled, so it can neither stall nor launch a mult/div
   assign hazard   = (lu_haz || md_haz) && !FLUSH && !RESET;
   assign STALL    = hazard;
   assign BUBBLE   = hazard;
   assign md_start = ID_MD_START && !hazard && !FLUSH;

   md_busy_timer #(
      .MD_LAT (MD_LAT)
   ) u_md_timer (
      .CLK     (CLK),
      .RESET   (RESET),
      .start   (md_start),
      .MD_BUSY (MD_BUSY),
      .MD_DONE (MD_DONE)
   );

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign STALL_CNT = stall_cnt_q;
`else
   assign STALL_CNT = '0;
`endif

endmodule
